line_window_gen: RTL and testbench

LINE_WINDOW_GEN -- requirements
Module: line_window_gen

---
 rtl/sobel_pkg.sv | 11 +
 rtl/line_window_gen_if.sv | 46 ++++
 rtl/line_buffer.sv | 34 +++
 rtl/line_window_gen.sv | 151 +++++++++++++++
 tb/tb_line_window_gen.sv | 285 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/sobel_pkg.sv
// Shared constants and types for the 3x3 line-window generator.
package sobel_pkg;

  localparam int PIX_W = 8;

  typedef enum logic {
    FILL   = 1'b0,
    STREAM = 1'b1
  } win_state_t;

endpackage

// File: rtl/line_window_gen_if.sv
// Pixel-in / window-out signal bundle for line_window_gen.
// err_o exists only when WIN_ERR_EN is defined.
interface line_window_gen_if;

  logic [sobel_pkg::PIX_W-1:0] pixel_i;
  logic                        valid_i;
  logic                        sof_i;
  logic [sobel_pkg::PIX_W-1:0] data_0_o;
  logic [sobel_pkg::PIX_W-1:0] data_1_o;
  logic [sobel_pkg::PIX_W-1:0] data_2_o;
  logic [sobel_pkg::PIX_W-1:0] data_3_o;
  logic [sobel_pkg::PIX_W-1:0] data_4_o;
  logic [sobel_pkg::PIX_W-1:0] data_5_o;
  logic [sobel_pkg::PIX_W-1:0] data_6_o;
  logic [sobel_pkg::PIX_W-1:0] data_7_o;
  logic [sobel_pkg::PIX_W-1:0] data_8_o;
  logic                        done_o;
`ifdef WIN_ERR_EN
  logic                        err_o;

  modport master (
    output pixel_i, valid_i, sof_i,
    input  data_0_o, data_1_o, data_2_o, data_3_o, data_4_o,
    input  data_5_o, data_6_o, data_7_o, data_8_o, done_o, err_o
  );

  modport slave (
    input  pixel_i, valid_i, sof_i,
    output data_0_o, data_1_o, data_2_o, data_3_o, data_4_o,
    output data_5_o, data_6_o, data_7_o, data_8_o, done_o, err_o
  );
`else
  modport master (
    output pixel_i, valid_i, sof_i,
    input  data_0_o, data_1_o, data_2_o, data_3_o, data_4_o,
    input  data_5_o, data_6_o, data_7_o, data_8_o, done_o
  );

  modport slave (
    input  pixel_i, valid_i, sof_i,
    output data_0_o, data_1_o, data_2_o, data_3_o, data_4_o,
    output data_5_o, data_6_o, data_7_o, data_8_o, done_o
  );
`endif

endinterface

// File: rtl/line_buffer.sv
// One-line delay: circular RAM, read-then-overwrite at the same address.
// Output is the pixel written exactly DEPTH enables earlier.
module line_buffer
  import sobel_pkg::*;
#(
  parameter int DEPTH = 640
) (
  input  logic             sys_clk_i,
  input  logic             sys_rst_i,
  input  logic             en,
  input  logic [PIX_W-1:0] din,
  output logic [PIX_W-1:0] dout
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] PTR_LAST = AW'(DEPTH - 1);

  logic [PIX_W-1:0] mem [DEPTH];
  logic [AW-1:0]    ptr;

  // RAM write port; contents need no reset
  always_ff @(posedge sys_clk_i) begin
    if (en) mem[ptr] <= din;
  end

  // Address pointer walks the ring once per line
  always_ff @(posedge sys_clk_i) begin
    if (sys_rst_i)   ptr <= '0;
    else if (en)     ptr <= (ptr == PTR_LAST) ? '0 : ptr + 1'b1;
  end

  assign dout = mem[ptr];

endmodule

// File: rtl/line_window_gen.sv
// Raster-order pixel stream to 3x3 window generator.
// Optional feature: define WIN_ERR_EN to get the sticky truncated-frame flag err_o.
//
// state  | meaning
// FILL   | rows 0..1 of a frame, line buffers priming, no windows
// STREAM | rows 2..last, window emitted for every pixel with col >= 2
module line_window_gen
  import sobel_pkg::*;
#(
  parameter int IMG_WIDTH  = 640,
  parameter int IMG_HEIGHT = 480
) (
  input  logic             sys_clk_i,
  input  logic             sys_rst_i,
  line_window_gen_if.slave bus
);

  localparam int CW = $clog2(IMG_WIDTH);
  localparam int RW = $clog2(IMG_HEIGHT);
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT - 1);

  logic [CW-1:0]    col;
  logic [RW-1:0]    row;
  win_state_t       state, state_nxt;
  logic             accept, line_end, frame_end, emit, done_q;
  logic [PIX_W-1:0] line1, line2;
  logic [PIX_W-1:0] win     [9];
  logic [PIX_W-1:0] win_nxt [9];
  logic [PIX_W-1:0] data_q  [9];

  assign accept    = bus.valid_i;
  assign line_end  = (col == COL_LAST);
  assign frame_end = line_end && (row == ROW_LAST);

  line_buffer #(.DEPTH(IMG_WIDTH)) u_line1 (
    .sys_clk_i (sys_clk_i),
    .sys_rst_i (sys_rst_i),
    .en        (accept),
    .din       (bus.pixel_i),
    .dout      (line1)
  );

  line_buffer #(.DEPTH(IMG_WIDTH)) u_line2 (
    .sys_clk_i (sys_clk_i),
    .sys_rst_i (sys_rst_i),
    .en        (accept),
    .din       (line1),
    .dout      (line2)
  );

  // Raster position; an sof pixel is (0,0) so the counters land on (0,1)
  always_ff @(posedge sys_clk_i) begin
    if (sys_rst_i) begin
      col <= '0;
      row <= '0;
    end else if (accept) begin
      if (bus.sof_i) begin
        col <= CW'(1);
        row <= '0;
      end else if (line_end) begin
        col <= '0;
        row <= (row == ROW_LAST) ? '0 : row + 1'b1;
      end else begin
        col <= col + 1'b1;
      end
    end
  end

  // State register
  always_ff @(posedge sys_clk_i) begin
    if (sys_rst_i) state <= FILL;
    else           state <= state_nxt;
  end

  // Next state and window-emit decision
  always_comb begin
    state_nxt = state;
    emit      = 1'b0;
    if (accept) begin
      if (bus.sof_i) begin
        state_nxt = FILL;
      end else begin
        case (state)
          FILL: begin
            if (line_end && (row == RW'(1))) state_nxt = STREAM;
          end
          STREAM: begin
            emit = (col >= CW'(2));
            if (frame_end) state_nxt = FILL;
          end
          default: state_nxt = FILL;
        endcase
      end
    end
  end

  // Shift window left; new right column is {line2, line1, pixel}
  always_comb begin
    for (int r = 0; r < 3; r++) begin
      win_nxt[r*3]     = win[r*3+1];
      win_nxt[r*3 + 1] = win[r*3+2];
    end
    win_nxt[2] = line2;
    win_nxt[5] = line1;
    win_nxt[8] = bus.pixel_i;
  end

  // Window shift register and held output copy, updated only on emit
  always_ff @(posedge sys_clk_i) begin
    if (sys_rst_i) begin
      for (int i = 0; i < 9; i++) begin
        win[i]    <= '0;
        data_q[i] <= '0;
      end
      done_q <= 1'b0;
    end else begin
      done_q <= emit;
      if (accept) begin
        for (int i = 0; i < 9; i++) win[i] <= win_nxt[i];
      end
      if (emit) begin
        for (int i = 0; i < 9; i++) data_q[i] <= win_nxt[i];
      end
    end
  end

  assign bus.data_0_o = data_q[0];
  assign bus.data_1_o = data_q[1];
  assign bus.data_2_o = data_q[2];
  assign bus.data_3_o = data_q[3];
  assign bus.data_4_o = data_q[4];
  assign bus.data_5_o = data_q[5];
  assign bus.data_6_o = data_q[6];
  assign bus.data_7_o = data_q[7];
  assign bus.data_8_o = data_q[8];
  assign bus.done_o   = done_q;

`ifdef WIN_ERR_EN
  logic err_q;

  // Sticky flag: a frame was cut short by an early sof
  always_ff @(posedge sys_clk_i) begin
    if (sys_rst_i)                                          err_q <= 1'b0;
    else if (accept && bus.sof_i && ((col != '0) || (row != '0))) err_q <= 1'b1;
  end

  assign bus.err_o = err_q;
`endif

endmodule

// File: tb/tb_line_window_gen.sv
// Self-checking bench for line_window_gen on a 5x4 image.
// Reference model stores the current frame as a 2-D image and cuts windows out of it.
module tb_line_window_gen;

  localparam int W = 5;
  localparam int H = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;

  line_window_gen_if bus();

  line_window_gen #(.IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (
    .sys_clk_i (clk),
    .sys_rst_i (rst),
    .bus       (bus.slave)
  );

  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;
  int dut_wins    = 0;

  int         mr, mc, lr, lc;
  logic [7:0] img [H][W];
  logic [7:0] exp_win [9];
  logic       exp_done;
  logic       exp_err;

  function automatic logic [7:0] dut_data(input int i);
    case (i)
      0: return bus.data_0_o;
      1: return bus.data_1_o;
      2: return bus.data_2_o;
      3: return bus.data_3_o;
      4: return bus.data_4_o;
      5: return bus.data_5_o;
      6: return bus.data_6_o;
      7: return bus.data_7_o;
      default: return bus.data_8_o;
    endcase
  endfunction

  task automatic model_reset();
    mr = 0; mc = 0;
    exp_done = 1'b0;
    exp_err  = 1'b0;
    for (int i = 0; i < 9; i++) exp_win[i] = 8'h00;
  endtask

  task automatic model_accept(input logic [7:0] p, input logic s);
    if (s) begin
      if (mr != 0 || mc != 0) exp_err = 1'b1;
      mr = 0; mc = 0;
    end
    lr = mr; lc = mc;
    img[mr][mc] = p;
    exp_done = (mr >= 2 && mc >= 2);
    if (exp_done)
      for (int i = 0; i < 3; i++)
        for (int j = 0; j < 3; j++)
          exp_win[i*3+j] = img[mr-2+i][mc-2+j];
    mc++;
    if (mc == W) begin
      mc = 0; mr++;
      if (mr == H) mr = 0;
    end
  endtask

  task automatic apply_pixel(input logic [7:0] p, input logic s, input int gap);
    model_accept(p, s);
    @(negedge clk);
    bus.pixel_i = p;
    bus.valid_i = 1'b1;
    bus.sof_i   = s;
    @(posedge clk); #1;
    bus.valid_i = 1'b0;
    bus.sof_i   = 1'($urandom_range(0, 1));
    bus.pixel_i = 8'($urandom);
    vectors++;
    if (bus.done_o !== exp_done) begin
      miscompares++;
      $display("FAIL done at (%0d,%0d): got %b want %b", lr, lc, bus.done_o, exp_done);
    end
    if (bus.done_o === 1'b1) dut_wins++;
    for (int i = 0; i < 9; i++) begin
      vectors++;
      if (dut_data(i) !== exp_win[i]) begin
        miscompares++;
        $display("FAIL data_%0d at (%0d,%0d): got %h want %h", i, lr, lc, dut_data(i), exp_win[i]);
      end
    end
`ifdef WIN_ERR_EN
    vectors++;
    if (bus.err_o !== exp_err) begin
      miscompares++;
      $display("FAIL err at (%0d,%0d): got %b want %b", lr, lc, bus.err_o, exp_err);
    end
`endif
    for (int g = 0; g < gap; g++) begin
      @(posedge clk); #1;
      vectors++;
      if (bus.done_o !== 1'b0) begin
        miscompares++;
        $display("FAIL idle_done after (%0d,%0d): got %b want 0", lr, lc, bus.done_o);
      end
      for (int i = 0; i < 9; i++) begin
        vectors++;
        if (dut_data(i) !== exp_win[i]) begin
          miscompares++;
          $display("FAIL idle_data_%0d after (%0d,%0d): got %h want %h", i, lr, lc, dut_data(i), exp_win[i]);
        end
      end
    end
  endtask

  task automatic pulse_reset(input int cycles);
    @(negedge clk);
    rst = 1'b1;
    repeat (cycles) @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    pulse_reset(3);
    vectors++;
    if (bus.done_o !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_done: got %b want 0", bus.done_o);
    end
    for (int i = 0; i < 9; i++) begin
      vectors++;
      if (dut_data(i) !== 8'h00) begin
        miscompares++;
        $display("FAIL reset_data_%0d: got %h want 00", i, dut_data(i));
      end
    end
`ifdef WIN_ERR_EN
    vectors++;
    if (bus.err_o !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_err: got %b want 0", bus.err_o);
    end
`endif
  endtask

  task automatic test_stream(input int gap);
    dut_wins = 0;
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++) begin
        apply_pixel(8'(r*16 + c), (r == 0 && c == 0), gap);
        if (r == 2 && c == 2) begin
          vectors += 3;
          if (bus.data_0_o !== 8'h00 || bus.data_4_o !== 8'h11 || bus.data_8_o !== 8'h22) begin
            miscompares++;
            $display("FAIL first_window gap=%0d: got %h/%h/%h want 00/11/22",
                     gap, bus.data_0_o, bus.data_4_o, bus.data_8_o);
          end
        end
        if (r == 3 && c == 2) begin
          vectors += 2;
          if (bus.data_0_o !== 8'h10 || bus.data_8_o !== 8'h32) begin
            miscompares++;
            $display("FAIL row_wrap_window gap=%0d: got %h/%h want 10/32",
                     gap, bus.data_0_o, bus.data_8_o);
          end
        end
      end
    vectors++;
    if (dut_wins !== 6) begin
      miscompares++;
      $display("FAIL window_count gap=%0d: got %0d want 6", gap, dut_wins);
    end
  endtask

  task automatic test_back_to_back();
    dut_wins = 0;
    for (int f = 0; f < 2; f++)
      for (int r = 0; r < H; r++)
        for (int c = 0; c < W; c++) begin
          apply_pixel((f == 0) ? 8'(r*16 + c) : 8'(8'hF0 + c), (r == 0 && c == 0), 0);
          if (f == 1 && bus.done_o === 1'b1)
            for (int i = 0; i < 9; i++) begin
              vectors++;
              if (dut_data(i) < 8'hF0 || dut_data(i) > 8'hF4) begin
                miscompares++;
                $display("FAIL b2b_range data_%0d at (%0d,%0d): got %h want F0..F4", i, r, c, dut_data(i));
              end
            end
        end
    vectors++;
    if (dut_wins !== 12) begin
      miscompares++;
      $display("FAIL b2b_count: got %0d want 12", dut_wins);
    end
  endtask

  task automatic test_sof_abort();
    for (int k = 0; k < 2*W + 3; k++)
      apply_pixel(8'((k / W)*16 + (k % W)), (k == 0), 0);
    dut_wins = 0;
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++)
        apply_pixel(8'(8'h80 + r*16 + c), (r == 0 && c == 0), 1);
    vectors++;
    if (dut_wins !== 6) begin
      miscompares++;
      $display("FAIL sof_abort_count: got %0d want 6", dut_wins);
    end
`ifdef WIN_ERR_EN
    vectors++;
    if (bus.err_o !== 1'b1) begin
      miscompares++;
      $display("FAIL sof_abort_err: got %b want 1", bus.err_o);
    end
`endif
  endtask

  task automatic test_mid_reset();
    for (int k = 0; k < 3*W + 1; k++)
      apply_pixel(8'(8'h40 + k), (k == 0), 0);
    pulse_reset(1);
    vectors++;
    if (bus.done_o !== 1'b0) begin
      miscompares++;
      $display("FAIL midreset_done: got %b want 0", bus.done_o);
    end
    for (int i = 0; i < 9; i++) begin
      vectors++;
      if (dut_data(i) !== 8'h00) begin
        miscompares++;
        $display("FAIL midreset_data_%0d: got %h want 00", i, dut_data(i));
      end
    end
`ifdef WIN_ERR_EN
    vectors++;
    if (bus.err_o !== 1'b0) begin
      miscompares++;
      $display("FAIL midreset_err: got %b want 0", bus.err_o);
    end
`endif
    dut_wins = 0;
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++) begin
        apply_pixel(8'(r*16 + c + 1), 1'b0, 0);
        if (r == 2 && c == 2) begin
          vectors++;
          if (bus.data_0_o !== 8'h01) begin
            miscompares++;
            $display("FAIL midreset_first_window: got %h want 01", bus.data_0_o);
          end
        end
      end
    vectors++;
    if (dut_wins !== 6) begin
      miscompares++;
      $display("FAIL midreset_count: got %0d want 6", dut_wins);
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 120; k++)
      apply_pixel(8'($urandom), ($urandom_range(0, 29) == 0), $urandom_range(0, 2));
  endtask

  initial begin
    bus.pixel_i = 8'h00;
    bus.valid_i = 1'b0;
    bus.sof_i   = 1'b0;
    model_reset();
    test_reset();
    test_stream(0);
    test_stream(3);
    test_back_to_back();
    test_sof_abort();
    test_mid_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
